// File: rtl/core_bp_update_pkg.sv
// Shared definitions for the branch-predictor update path: 2-bit counter
// encodings, FSM states and the saturating counter step used with core_pht.
package core_bp_update_pkg;

  localparam int PC_W_DEF = 10;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } bp_state_e;

  function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST)  ? ST  : cnt + 2'b01;
    else       return (cnt == SNT) ? SNT : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/core_bp_update_if.sv
// IF/ID capture, branch resolution and PHT update bundle for core_bp_update.
interface core_bp_update_if
  import core_bp_update_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = 16
);
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic             if_pred;
  logic [1:0]       if_pht;
  logic             id_stall;
  logic             id_is_branch;
  logic             id_taken_res;
  logic [PC_W-1:0]  id_pc;
  logic             update_BP;
  logic             pred_right;
  logic             taken;
  logic [1:0]       delayed_PHT;
  logic             redirect;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mp_cnt;

  modport master (
    output if_valid, if_pc, if_pred, if_pht, id_stall, id_is_branch, id_taken_res,
    input  id_pc, update_BP, pred_right, taken, delayed_PHT, redirect, br_cnt, mp_cnt
  );

  modport slave (
    input  if_valid, if_pc, if_pred, if_pht, id_stall, id_is_branch, id_taken_res,
    output id_pc, update_BP, pred_right, taken, delayed_PHT, redirect, br_cnt, mp_cnt
  );
endinterface

// File: rtl/core_bp_update_satcnt.sv
// Statistics counter that counts up on inc_i and sticks at all-ones.
module core_bp_satcnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/core_bp_update.sv
// ID-stage write-side driver for core_pht: carries the IF prediction to ID,
// checks it against the resolved outcome and drives the PHT update port.
//
// state   | meaning
// IDLE    | normal operation, ID branches may fire
// RECOVER | post-mispredict flush, ID captures invalidated, fire blocked
module core_bp_update
  import core_bp_update_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int RECOVER_CYC = 1,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst,
  core_bp_update_if.slave  bus
);
  localparam logic [2:0] REC_LOAD = 3'(RECOVER_CYC);

  bp_state_e state_q, state_d;
  logic [2:0] rec_q, rec_d;

  logic            v_q;
  logic [PC_W-1:0] pc_q;
  logic            pred_q;
  logic [1:0]      pht_q;

  logic            upd_q;
  logic [PC_W-1:0] id_pc_q;
  logic            taken_q;
  logic            pred_right_q;
  logic [1:0]      dpht_q;
  logic            redirect_q;

  logic            fire, mispredict, bypass;
  logic [1:0]      cap_pht;

  assign fire       = v_q & bus.id_is_branch & ~bus.id_stall & (state_q == IDLE);
  assign mispredict = fire & (pred_q != bus.id_taken_res);

  // The PHT write lands too late for a same-index IF read, so forward it.
  assign bypass  = upd_q & (bus.if_pc == id_pc_q);
  assign cap_pht = bypass ? sat2_next(dpht_q, taken_q) : bus.if_pht;

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d = RECOVER;
          rec_d   = REC_LOAD;
        end
      end
      RECOVER: begin
        if (!bus.id_stall) begin
          if (rec_q == 3'd1) begin
            state_d = IDLE;
            rec_d   = '0;
          end else begin
            rec_d = rec_q - 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q    <= 1'b0;
      pc_q   <= '0;
      pred_q <= 1'b0;
      pht_q  <= '0;
    end else if (!bus.id_stall) begin
      v_q    <= bus.if_valid & (state_q == IDLE);
      pc_q   <= bus.if_pc;
      pred_q <= bus.if_pred;
      pht_q  <= cap_pht;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_q        <= 1'b0;
      redirect_q   <= 1'b0;
      id_pc_q      <= '0;
      taken_q      <= 1'b0;
      pred_right_q <= 1'b0;
      dpht_q       <= '0;
    end else begin
      upd_q      <= fire;
      redirect_q <= mispredict;
      if (fire) begin
        id_pc_q      <= pc_q;
        taken_q      <= bus.id_taken_res;
        pred_right_q <= (pred_q == bus.id_taken_res);
        dpht_q       <= pht_q;
      end
    end
  end

  core_bp_satcnt #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (fire),
    .cnt_o (bus.br_cnt)
  );

  core_bp_satcnt #(.CNT_W(CNT_W)) u_mp_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (mispredict),
    .cnt_o (bus.mp_cnt)
  );

  assign bus.id_pc       = id_pc_q;
  assign bus.update_BP   = upd_q;
  assign bus.pred_right  = pred_right_q;
  assign bus.taken       = taken_q;
  assign bus.delayed_PHT = dpht_q;
  assign bus.redirect    = redirect_q;
endmodule

// File: tb/tb_core_bp_update.sv
// Directed bench for core_bp_update (PC_W=11, RECOVER_CYC=2, CNT_W=4).
module tb_core_bp_update;
  localparam int PC_W = 11;
  localparam int REC  = 2;
  localparam int CW   = 4;

  logic clk;
  logic rst;
  int   vec  = 0;
  int   miss = 0;
  int   exp_br = 0;
  int   exp_mp = 0;

  core_bp_update_if #(.PC_W(PC_W), .CNT_W(CW)) bus ();

  core_bp_update #(.PC_W(PC_W), .RECOVER_CYC(REC), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sinc(input int c);
    return (c >= 15) ? 15 : c + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_upd(input string tag, input int pc, input int t, input int pr,
                         input int pht, input int rd);
    chk({tag, ".upd"},   32'(bus.update_BP),   1);
    chk({tag, ".pc"},    32'(bus.id_pc),       32'(pc));
    chk({tag, ".taken"}, 32'(bus.taken),       32'(t));
    chk({tag, ".right"}, 32'(bus.pred_right),  32'(pr));
    chk({tag, ".pht"},   32'(bus.delayed_PHT), 32'(pht));
    chk({tag, ".redir"}, 32'(bus.redirect),    32'(rd));
    chk({tag, ".br"},    32'(bus.br_cnt),      32'(exp_br));
    chk({tag, ".mp"},    32'(bus.mp_cnt),      32'(exp_mp));
  endtask

  task automatic issue(input int pc, input int pred, input int pht);
    bus.if_valid     = 1'b1;
    bus.if_pc        = 11'(pc);
    bus.if_pred      = 1'(pred);
    bus.if_pht       = 2'(pht);
    bus.id_is_branch = 1'b0;
    tick();
    bus.if_valid     = 1'b0;
  endtask

  task automatic resolve(input int t);
    bus.id_is_branch = 1'b1;
    bus.id_taken_res = 1'(t);
    tick();
    bus.id_is_branch = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.if_valid = 0; bus.if_pc = 0; bus.if_pred = 0; bus.if_pht = 0;
    bus.id_stall = 0; bus.id_is_branch = 0; bus.id_taken_res = 0;
    for (int i = 0; i < 4; i++) begin
      bus.if_valid     = 1'($urandom);
      bus.if_pc        = 11'($urandom);
      bus.if_pred      = 1'($urandom);
      bus.if_pht       = 2'($urandom);
      bus.id_stall     = 1'($urandom);
      bus.id_is_branch = 1'($urandom);
      bus.id_taken_res = 1'($urandom);
      tick();
    end
    chk("rst.upd",   32'(bus.update_BP),   0);
    chk("rst.pc",    32'(bus.id_pc),       0);
    chk("rst.taken", 32'(bus.taken),       0);
    chk("rst.right", 32'(bus.pred_right),  0);
    chk("rst.pht",   32'(bus.delayed_PHT), 0);
    chk("rst.redir", 32'(bus.redirect),    0);
    chk("rst.br",    32'(bus.br_cnt),      0);
    chk("rst.mp",    32'(bus.mp_cnt),      0);
    bus.if_valid = 0; bus.if_pc = 0; bus.if_pred = 0; bus.if_pht = 0;
    bus.id_stall = 0; bus.id_is_branch = 0; bus.id_taken_res = 0;
    rst = 1'b1;
    tick();

    // correct not-taken prediction
    issue(1430, 0, 0);
    resolve(0);
    exp_br = sinc(exp_br);
    chk_upd("ok", 1430, 0, 1, 0, 0);
    tick();
    chk("ok_next.upd", 32'(bus.update_BP), 0);
    chk("ok_next.pc",  32'(bus.id_pc),     1430);

    // mispredict, wrong-path IF captures during recovery are dropped
    issue(1450, 0, 1);
    bus.id_is_branch = 1; bus.id_taken_res = 1;
    bus.if_valid = 1; bus.if_pc = 100; bus.if_pred = 1; bus.if_pht = 2;
    tick();
    exp_br = sinc(exp_br); exp_mp = sinc(exp_mp);
    chk_upd("mis", 1450, 1, 0, 1, 1);
    bus.if_pc = 200;
    tick();
    chk("rec1.upd",   32'(bus.update_BP), 0);
    chk("rec1.redir", 32'(bus.redirect),  0);
    tick();
    chk("rec2.upd", 32'(bus.update_BP), 0);
    bus.if_pc = 300; bus.if_pred = 1; bus.if_pht = 3;
    tick();
    chk("rec3.upd", 32'(bus.update_BP), 0);
    bus.if_valid = 0;
    tick();
    exp_br = sinc(exp_br);
    chk_upd("post_rec", 300, 1, 1, 3, 0);
    bus.id_is_branch = 0;

    // bypass chain on pc 1430, including both saturation ends
    issue(1430, 1, 1); resolve(1); exp_br = sinc(exp_br); chk_upd("byp1",   1430, 1, 1, 1, 0);
    issue(1430, 1, 1); resolve(1); exp_br = sinc(exp_br); chk_upd("byp2",   1430, 1, 1, 2, 0);
    issue(1430, 1, 3); resolve(1); exp_br = sinc(exp_br); chk_upd("byp3",   1430, 1, 1, 3, 0);
    issue(1430, 0, 0); resolve(0); exp_br = sinc(exp_br); chk_upd("sat_hi", 1430, 0, 1, 3, 0);
    issue(1430, 0, 3); resolve(0); exp_br = sinc(exp_br); chk_upd("dec1",   1430, 0, 1, 2, 0);
    issue(1430, 0, 3); resolve(0); exp_br = sinc(exp_br); chk_upd("dec2",   1430, 0, 1, 1, 0);
    issue(1430, 0, 3); resolve(0); exp_br = sinc(exp_br); chk_upd("dec3",   1430, 0, 1, 0, 0);
    issue(1430, 0, 3); resolve(0); exp_br = sinc(exp_br); chk_upd("sat_lo", 1430, 0, 1, 0, 0);
    issue(1431, 0, 2); resolve(0); exp_br = sinc(exp_br); chk_upd("nobyp",  1431, 0, 1, 2, 0);

    // valid non-branch in ID
    issue(50, 1, 3);
    tick();
    chk("nonbr.upd",   32'(bus.update_BP), 0);
    chk("nonbr.redir", 32'(bus.redirect),  0);
    chk("nonbr.br",    32'(bus.br_cnt),    32'(exp_br));

    // resolved branch held by a 3-cycle stall fires exactly once
    issue(700, 1, 2);
    bus.id_is_branch = 1; bus.id_taken_res = 1; bus.id_stall = 1;
    bus.if_valid = 1; bus.if_pc = 800;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.upd", 32'(bus.update_BP), 0);
    end
    bus.if_valid = 0; bus.id_stall = 0;
    tick();
    exp_br = sinc(exp_br);
    chk_upd("stall_rel", 700, 1, 1, 2, 0);
    tick();
    chk("stall_once.upd", 32'(bus.update_BP), 0);
    chk("stall_once.br",  32'(bus.br_cnt),    32'(exp_br));
    bus.id_is_branch = 0;

    // stall during RECOVER freezes the recovery counter
    issue(900, 0, 1);
    resolve(1);
    exp_br = sinc(exp_br); exp_mp = sinc(exp_mp);
    chk_upd("mis2", 900, 1, 0, 1, 1);
    bus.id_stall = 1;
    tick();
    chk("recst.redir", 32'(bus.redirect), 0);
    tick();
    bus.id_stall = 0;
    bus.if_valid = 1; bus.if_pc = 950; bus.if_pred = 0; bus.if_pht = 0;
    bus.id_is_branch = 1; bus.id_taken_res = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("recst.upd", 32'(bus.update_BP), 0);
    end
    bus.if_valid = 0;
    tick();
    exp_br = sinc(exp_br);
    chk_upd("recst_fire", 950, 0, 1, 0, 0);
    bus.id_is_branch = 0;

    // drive both counters into saturation with repeated mispredicts
    for (int i = 0; i < 15; i++) begin
      issue(600, 0, 0);
      resolve(1);
      exp_br = sinc(exp_br); exp_mp = sinc(exp_mp);
      chk("satloop.mp",    32'(bus.mp_cnt),   32'(exp_mp));
      chk("satloop.br",    32'(bus.br_cnt),   32'(exp_br));
      chk("satloop.redir", 32'(bus.redirect), 1);
      tick();
      tick();
    end
    chk("sat.mp", 32'(bus.mp_cnt), 15);
    chk("sat.br", 32'(bus.br_cnt), 15);

    // reset mid-operation with an update presented and a branch pending in ID
    issue(77, 1, 1);
    bus.id_is_branch = 1; bus.id_taken_res = 1;
    bus.if_valid = 1; bus.if_pc = 78; bus.if_pred = 1;
    tick();
    chk("pre_rst.upd", 32'(bus.update_BP), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst.upd", 32'(bus.update_BP),   0);
    chk("mid_rst.pc",  32'(bus.id_pc),       0);
    chk("mid_rst.pht", 32'(bus.delayed_PHT), 0);
    chk("mid_rst.br",  32'(bus.br_cnt),      0);
    chk("mid_rst.mp",  32'(bus.mp_cnt),      0);
    bus.if_valid = 0;
    rst = 1'b1;
    tick();
    chk("after_rst.upd", 32'(bus.update_BP), 0);
    chk("after_rst.br",  32'(bus.br_cnt),    0);
    bus.id_is_branch = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/core_bp_update.md
Name: core_bp_update

Overview:
- ID-stage companion to core_pht: the write-side driver of the direction predictor.
- Captures the IF-stage prediction (pc slice, pred_out, PHT_out) and carries it one stage to ID.
- Compares it against the branch outcome resolved in ID, then drives the PHT update port (id_pc, update_BP, pred_right, taken, delayed_PHT).
- Raises a one-cycle redirect on mispredict and keeps branch/mispredict statistics.

Parameters:
- PC_W, 10, width of pc slice used to index the PHT.
- RECOVER_CYC, 1, cycles the IF→ID capture is discarded after a mispredict (1..7).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_valid  in  1  IF holds a real instruction this cycle.
- if_pc  in  PC_W  pc slice of the IF instruction.
- if_pred  in  1  pred_out from core_pht (1 = taken).
- if_pht  in  2  PHT_out from core_pht.
- id_stall  in  1  ID stage held; the ID register keeps its contents.
- id_is_branch  in  1  instruction in ID is a conditional branch.
- id_taken_res  in  1  resolved direction in ID, qualified by id_is_branch.
- id_pc  out  PC_W  to core_pht, pc of the branch being updated.
- update_BP  out  1  to core_pht, update strobe.
- pred_right  out  1  to core_pht, prediction matched the outcome.
- taken  out  1  to core_pht, resolved direction.
- delayed_PHT  out  2  to core_pht, PHT counter as read at IF (bypassed).
- redirect  out  1  one-cycle mispredict pulse to fetch/flush logic.
- br_cnt  out  CNT_W  resolved-branch count.
- mp_cnt  out  CNT_W  mispredict count.

Behaviour:
- Reset (rst=0, async): all outputs and internal registers are 0; FSM enters IDLE; ID register is invalid.
- ID register fields: v, pc, pred, pht.
  - Loads when !id_stall: v <= if_valid & (state==IDLE), plus pc/pred/pht from IF.
  - Holds when id_stall.
- Resolve condition: fire = v & id_is_branch & !id_stall & (state==IDLE). This is combinational in ID.
- Update outputs are registered, one cycle after fire:
  - update_BP=1, id_pc=pc, taken=id_taken_res, pred_right=(pred==id_taken_res), delayed_PHT=pht.
  - When fire=0 on a cycle: update_BP=0 next cycle; the other update outputs hold their last values.
- Bypass rule:
  - Applies when the IF capture occurs in the same cycle an update is presented (update_BP=1) and if_pc==id_pc.
  - The captured pht is then sat(delayed_PHT, taken): taken increments and saturates at 2'b11; not-taken decrements and saturates at 2'b00.
  - The comparison uses the pc slice only (conservative alias).
- redirect: 1 for exactly the cycle after a fire with pred!=id_taken_res; coincides with update_BP.
- FSM:
  - IDLE → RECOVER on a mispredicting fire; the recovery counter loads RECOVER_CYC.
  - RECOVER: ID register loads v=0; fire is blocked; the counter decrements each non-stalled cycle.
  - RECOVER → IDLE when the counter reaches 1 and the cycle is not stalled.
- Simultaneous events:
  - id_stall during RECOVER freezes the counter.
  - A stalled ID branch never fires, and fires at most once after stall release.
- Counters, incremented in the cycle update_BP is registered:
  - br_cnt += 1 on every fire.
  - mp_cnt += 1 on mispredicts.
  - Both saturate at all-ones and never wrap.
- Non-branch (v=1, id_is_branch=0): no update, no redirect, no counter change.
- Reset mid-operation: immediate return to the reset state; no pending update survives.

Decomposition:
- Shared package/define file:
  - PC_W default.
  - 2-bit counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - FSM state constants IDLE/RECOVER.
  - Saturating 2-bit next-state function, shared with core_pht.
- One natural sub-module: core_bp_satcnt (generic CNT_W saturating counter with inc enable), instantiated twice for br_cnt/mp_cnt.

Test Plan:
- Reset: hold rst=0 with random inputs → all outputs 0; release → first fire possible one cycle after a valid capture.
- Correct prediction:
  - Stimulus: if_pc=1430, if_pred=0, if_pht=00, then id_is_branch=1, id_taken_res=0.
  - Response: next cycle update_BP=1, id_pc=1430, taken=0, pred_right=1, delayed_PHT=00, redirect=0, br_cnt=1, mp_cnt=0.
- Mispredict with RECOVER_CYC=1:
  - Stimulus: if_pc=1450, if_pred=0, if_pht=01, resolved taken=1.
  - Response: update_BP=1, pred_right=0, redirect=1, mp_cnt=1; the following IF capture is dropped (no update for it).
- Bypass:
  - Stimulus: back-to-back branches at pc 1430; first update taken=1 with delayed_PHT=01, while IF presents if_pht=01.
  - Response: second update carries delayed_PHT=10.
- Stall: id_stall=1 for 3 cycles on a resolved branch → no update_BP during the stall; exactly one update_BP after release; br_cnt increments once.
- Saturation: force 2^CNT_W-1 mispredicts (CNT_W=4 build) → mp_cnt stays 4'hF; sat(11,taken)=11 and sat(00,not-taken)=00 in the bypass path.
